serv_dbus_responder: RTL and testbench

Memory-side responder for the SERV data bus. Sits opposite the CPU's data buffer register: it accepts the address, write data, byte selects and write-enable the core presents during a load/store, and performs the access on an internal byte-lane RAM. It then returns a one-cycle ack and, for loads, the full 32-bit read word that the core latches. Configurable wait states let benches and small SoCs model slow memory.

---
 rtl/serv_dbus_responder.sv | 125 ++++++++++++
 tb/tb_serv_dbus_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serv_dbus_responder.sv
// Memory-side responder for the SERV data bus: captures a request, waits a
// configurable number of cycles, then performs the access on a byte-lane RAM.
module serv_dbus_responder #(
    parameter int DEPTH       = 1024,
    parameter int AW          = $clog2(DEPTH),
    parameter int WAIT_CYCLES = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_oob
);

    localparam int WORDS = DEPTH / 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        RECOVER
    } state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [AW-3:0] idx_q;
    logic [31:0]   dat_q;
    logic [3:0]    sel_q;
    logic          we_q;
    logic          in_range_q;
    logic          ack_q;
    logic          oob_q;
    logic [31:0]   rdt_q;

    logic [31:0]   mem [WORDS];

    logic          access;
    logic          in_range;
    logic          unused_adr_bits;

    // Word offset bits are dropped; the core always presents word-aligned lanes.
    assign unused_adr_bits = ^i_wb_adr[1:0];
    assign in_range        = (i_wb_adr >> AW) == 32'd0;
    // The access fires only while cyc is still high, so an abort on the same edge wins.
    assign access          = (state_q == WAIT) && i_wb_cyc && (cnt_q == 4'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            dat_q      <= 32'd0;
            sel_q      <= 4'd0;
            we_q       <= 1'b0;
            in_range_q <= 1'b0;
            ack_q      <= 1'b0;
            oob_q      <= 1'b0;
            rdt_q      <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_wb_cyc) begin
                        idx_q      <= i_wb_adr[AW-1:2];
                        dat_q      <= i_wb_dat;
                        sel_q      <= i_wb_sel;
                        we_q       <= i_wb_we;
                        in_range_q <= in_range;
                        cnt_q      <= 4'(WAIT_CYCLES);
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!i_wb_cyc) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 4'd0) begin
                        ack_q   <= 1'b1;
                        state_q <= ACK;
                        if (!we_q) begin
                            rdt_q <= in_range_q ? mem[idx_q] : 32'd0;
                        end
                        if (!in_range_q) begin
                            oob_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ACK: begin
                    ack_q   <= 1'b0;
                    state_q <= RECOVER;
                end
                RECOVER: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // NOTE: the RAM array has no reset; clearing it would need a multi-cycle
    // sweep and its power-up contents are undefined by design.
    always_ff @(posedge i_clk) begin
        if (!i_rst && access && we_q && in_range_q) begin
            for (int n = 0; n < 4; n++) begin
                if (sel_q[n]) begin
                    mem[idx_q][8*n +: 8] <= dat_q[8*n +: 8];
                end
            end
        end
    end

    assign o_wb_rdt = rdt_q;
    assign o_wb_ack = ack_q;
    assign o_oob    = oob_q;

endmodule

// File: tb/tb_serv_dbus_responder.sv
// Directed bench for serv_dbus_responder: three instances with 0, 3 and 4 wait
// states, each driven by its own bus signals from feature tasks.
module tb_serv_dbus_responder;

    logic        clk;
    logic        rst [3];
    logic [31:0] adr [3];
    logic [31:0] dat [3];
    logic [3:0]  sel [3];
    logic        we  [3];
    logic        cyc [3];
    logic [31:0] rdt [3];
    logic        ack [3];
    logic        oob [3];

    int tests = 0;
    int fails = 0;

    serv_dbus_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
        .i_clk(clk), .i_rst(rst[0]), .i_wb_adr(adr[0]), .i_wb_dat(dat[0]),
        .i_wb_sel(sel[0]), .i_wb_we(we[0]), .i_wb_cyc(cyc[0]),
        .o_wb_rdt(rdt[0]), .o_wb_ack(ack[0]), .o_oob(oob[0])
    );

    serv_dbus_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) u_w3 (
        .i_clk(clk), .i_rst(rst[1]), .i_wb_adr(adr[1]), .i_wb_dat(dat[1]),
        .i_wb_sel(sel[1]), .i_wb_we(we[1]), .i_wb_cyc(cyc[1]),
        .o_wb_rdt(rdt[1]), .o_wb_ack(ack[1]), .o_oob(oob[1])
    );

    serv_dbus_responder #(.DEPTH(1024), .WAIT_CYCLES(4)) u_w4 (
        .i_clk(clk), .i_rst(rst[2]), .i_wb_adr(adr[2]), .i_wb_dat(dat[2]),
        .i_wb_sel(sel[2]), .i_wb_we(we[2]), .i_wb_cyc(cyc[2]),
        .o_wb_rdt(rdt[2]), .o_wb_ack(ack[2]), .o_oob(oob[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One bus transaction. lat is the ack cycle counted from the capture cycle
    // (capture at edge N, ack visible after edge N+n gives lat = n+1), or -1.
    task automatic xfer(input int k, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input bit hold,
                        output int lat, output logic [31:0] r, output logic o,
                        output int extra, output logic [31:0] r_after);
        @(negedge clk);
        adr[k] = a; dat[k] = d; sel[k] = s; we[k] = w; cyc[k] = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ack[k]) begin
                lat = n + 1;
                break;
            end
        end
        r = rdt[k];
        o = oob[k];
        extra = 0;
        if (!hold) begin
            @(negedge clk);
            cyc[k] = 1'b0;
            adr[k] = 32'hFFFF_FFFF; dat[k] = 32'h5A5A_5A5A; sel[k] = 4'hF;
        end
        for (int n = 0; n < 2; n++) begin
            @(posedge clk); #1;
            if (ack[k]) extra++;
        end
        r_after = rdt[k];
        if (hold) begin
            @(negedge clk);
            cyc[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; cyc[k] = 1'b0; we[k] = 1'b0;
            adr[k] = 32'd0; dat[k] = 32'd0; sel[k] = 4'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            tests++; if (ack[k] !== 1'b0) begin fails++; $display("FAIL reset_ack[%0d]: got %b expected 0", k, ack[k]); end
            tests++; if (rdt[k] !== 32'd0) begin fails++; $display("FAIL reset_rdt[%0d]: got %h expected 0", k, rdt[k]); end
            tests++; if (oob[k] !== 1'b0) begin fails++; $display("FAIL reset_oob[%0d]: got %b expected 0", k, oob[k]); end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    endtask

    task automatic test_word();
        int lat, ex; logic [31:0] r, ra; logic o;
        xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, lat, r, o, ex, ra);
        tests++; if (lat !== 2) begin fails++; $display("FAIL w0_store_lat: got %0d expected 2", lat); end
        tests++; if (ex !== 0) begin fails++; $display("FAIL w0_store_extra_ack: got %0d expected 0", ex); end
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, lat, r, o, ex, ra);
        tests++; if (lat !== 2) begin fails++; $display("FAIL w0_load_lat: got %0d expected 2", lat); end
        tests++; if (r !== 32'hDEAD_BEEF) begin fails++; $display("FAIL w0_load_rdt: got %h expected deadbeef", r); end
        tests++; if (ra !== 32'hDEAD_BEEF) begin fails++; $display("FAIL w0_rdt_stable: got %h expected deadbeef", ra); end
        tests++; if (ex !== 0) begin fails++; $display("FAIL w0_load_extra_ack: got %0d expected 0", ex); end
    endtask

    task automatic test_byte_lanes();
        int lat, ex; logic [31:0] r, ra; logic o;
        xfer(0, 1'b1, 32'h10, 32'h0000_5500, 4'b0010, 1'b0, lat, r, o, ex, ra);
        tests++; if (r !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lane_store_rdt_hold: got %h expected deadbeef", r); end
        xfer(0, 1'b0, 32'h13, 32'h0, 4'b0000, 1'b0, lat, r, o, ex, ra);
        tests++; if (r !== 32'hDEAD_55EF) begin fails++; $display("FAIL lane_load_rdt: got %h expected dead55ef", r); end
        xfer(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b0, lat, r, o, ex, ra);
        tests++; if (lat !== 2) begin fails++; $display("FAIL sel0_store_lat: got %0d expected 2", lat); end
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, lat, r, o, ex, ra);
        tests++; if (r !== 32'hDEAD_55EF) begin fails++; $display("FAIL sel0_load_rdt: got %h expected dead55ef", r); end
    endtask

    task automatic test_wait_states();
        int lat, ex; logic [31:0] r, ra; logic o;
        xfer(1, 1'b1, 32'h40, 32'h1234_5678, 4'hF, 1'b0, lat, r, o, ex, ra);
        tests++; if (lat !== 5) begin fails++; $display("FAIL w3_store_lat: got %0d expected 5", lat); end
        xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b1, lat, r, o, ex, ra);
        tests++; if (lat !== 5) begin fails++; $display("FAIL w3_load_lat: got %0d expected 5", lat); end
        tests++; if (r !== 32'h1234_5678) begin fails++; $display("FAIL w3_load_rdt: got %h expected 12345678", r); end
        tests++; if (ex !== 0) begin fails++; $display("FAIL w3_hold_cyc_extra_ack: got %0d expected 0", ex); end
    endtask

    task automatic test_oob();
        int lat, ex; logic [31:0] r, ra; logic o;
        xfer(0, 1'b0, 32'h400, 32'h0, 4'hF, 1'b0, lat, r, o, ex, ra);
        tests++; if (lat !== 2) begin fails++; $display("FAIL oob_load_lat: got %0d expected 2", lat); end
        tests++; if (r !== 32'd0) begin fails++; $display("FAIL oob_load_rdt: got %h expected 0", r); end
        tests++; if (o !== 1'b1) begin fails++; $display("FAIL oob_flag_set: got %b expected 1", o); end
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, lat, r, o, ex, ra);
        tests++; if (r !== 32'hDEAD_55EF) begin fails++; $display("FAIL oob_inrange_rdt: got %h expected dead55ef", r); end
        tests++; if (o !== 1'b1) begin fails++; $display("FAIL oob_flag_sticky: got %b expected 1", o); end
        xfer(0, 1'b1, 32'h4, 32'h0102_0304, 4'hF, 1'b0, lat, r, o, ex, ra);
        xfer(0, 1'b1, 32'h404, 32'h9999_9999, 4'hF, 1'b0, lat, r, o, ex, ra);
        xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, lat, r, o, ex, ra);
        tests++; if (r !== 32'h0102_0304) begin fails++; $display("FAIL oob_store_no_write: got %h expected 01020304", r); end
        @(negedge clk); rst[0] = 1'b1;
        @(posedge clk); #1;
        tests++; if (oob[0] !== 1'b0) begin fails++; $display("FAIL oob_cleared_by_reset: got %b expected 0", oob[0]); end
        @(negedge clk); rst[0] = 1'b0;
    endtask

    task automatic test_abort();
        int lat, ex, acks; logic [31:0] r, ra; logic o;
        xfer(2, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0, lat, r, o, ex, ra);
        tests++; if (lat !== 6) begin fails++; $display("FAIL w4_store_lat: got %0d expected 6", lat); end
        // Drop cyc two cycles into the wait, then right as the counter hits zero.
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            adr[2] = 32'h20; dat[2] = 32'hAAAA_AAAA; sel[2] = 4'hF; we[2] = 1'b1; cyc[2] = 1'b1;
            @(posedge clk);
            repeat ((v == 0) ? 2 : 4) @(posedge clk);
            @(negedge clk); cyc[2] = 1'b0;
            acks = 0;
            for (int n = 0; n < 10; n++) begin
                @(posedge clk); #1;
                if (ack[2]) acks++;
            end
            tests++; if (acks !== 0) begin fails++; $display("FAIL abort%0d_no_ack: got %0d acks expected 0", v, acks); end
        end
        xfer(2, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, lat, r, o, ex, ra);
        tests++; if (lat !== 6) begin fails++; $display("FAIL abort_load_lat: got %0d expected 6", lat); end
        tests++; if (r !== 32'h1122_3344) begin fails++; $display("FAIL abort_old_data: got %h expected 11223344", r); end
    endtask

    task automatic test_reset_mid();
        int lat, ex, acks; logic [31:0] r, ra; logic o;
        xfer(1, 1'b0, 32'h800, 32'h0, 4'hF, 1'b0, lat, r, o, ex, ra);
        tests++; if (o !== 1'b1) begin fails++; $display("FAIL rmid_pre_oob: got %b expected 1", o); end
        xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, lat, r, o, ex, ra);
        tests++; if (r !== 32'h1234_5678) begin fails++; $display("FAIL rmid_pre_rdt: got %h expected 12345678", r); end
        @(negedge clk);
        adr[1] = 32'h40; dat[1] = 32'h0BAD_F00D; sel[1] = 4'hF; we[1] = 1'b1; cyc[1] = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk); rst[1] = 1'b1;
        @(posedge clk); #1;
        acks = ack[1] ? 1 : 0;
        tests++; if (rdt[1] !== 32'd0) begin fails++; $display("FAIL rmid_rdt: got %h expected 0", rdt[1]); end
        tests++; if (oob[1] !== 1'b0) begin fails++; $display("FAIL rmid_oob: got %b expected 0", oob[1]); end
        @(negedge clk); rst[1] = 1'b0; cyc[1] = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (ack[1]) acks++;
        end
        tests++; if (acks !== 0) begin fails++; $display("FAIL rmid_no_ack: got %0d acks expected 0", acks); end
        xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, lat, r, o, ex, ra);
        tests++; if (lat !== 5) begin fails++; $display("FAIL rmid_next_lat: got %0d expected 5", lat); end
        tests++; if (r !== 32'h1234_5678) begin fails++; $display("FAIL rmid_ram_unchanged: got %h expected 12345678", r); end
        tests++; if (o !== 1'b0) begin fails++; $display("FAIL rmid_next_oob: got %b expected 0", o); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_lanes();
        test_wait_states();
        test_oob();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
